// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left/right (serial or rotate), parallel load,
// with a saturating shift counter and a "drained" flag; active clock edge is selectable.
module universal_shift_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          NEG_EDGE = 1'b1,
  parameter int unsigned CW       = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  localparam logic [1:0]    MODE_HOLD = 2'b00;
  localparam logic [1:0]    MODE_SHR  = 2'b01;
  localparam logic [1:0]    MODE_SHL  = 2'b10;
  localparam logic [1:0]    MODE_LOAD = 2'b11;
  localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             drained_nxt;
  logic             shifting;

  // Next-state: clear beats enable, enable beats mode.
  always_comb begin
    q_nxt       = q;
    cnt_nxt     = shift_cnt;
    drained_nxt = drained;
    shifting    = 1'b0;
    if (clear) begin
      q_nxt       = '0;
      cnt_nxt     = '0;
      drained_nxt = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          q_nxt    = {(rot ? q[0] : sin_r), q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin_l)};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt       = d;
          cnt_nxt     = '0;
          drained_nxt = 1'b0;
        end
        default: ;
      endcase
      // Counter saturates; only a serial (non-rotating) shift can mark the register drained.
      if (shifting) begin
        cnt_nxt = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + CW'(1);
        if (!rot && (cnt_nxt == CNT_MAX)) begin
          drained_nxt = 1'b1;
        end
      end
    end
  end

  // Serial out follows the bit that the current mode would shift out.
  always_comb begin
    sout = 1'b0;
    case (mode)
      MODE_SHR: sout = q[0];
      MODE_SHL: sout = q[WIDTH-1];
      MODE_HOLD, MODE_LOAD: sout = 1'b0;
      default: sout = 1'b0;
    endcase
  end

  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
        q         <= '0;
        shift_cnt <= '0;
        drained   <= 1'b0;
      end else begin
        q         <= q_nxt;
        shift_cnt <= cnt_nxt;
        drained   <= drained_nxt;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        q         <= '0;
        shift_cnt <= '0;
        drained   <= 1'b0;
      end else begin
        q         <= q_nxt;
        shift_cnt <= cnt_nxt;
        drained   <= drained_nxt;
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed scenarios plus random operations
// compared against an arithmetic reference model (falling-edge instance), and an edge check on a rising-edge instance.
module tb_universal_shift_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       en;
  logic [1:0] mode;
  logic       rot;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] d;

  logic [7:0] q, q_p;
  logic       sout, sout_p;
  logic [3:0] shift_cnt, cnt_p;
  logic       drained, drained_p;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mq;
  int         mcnt;
  bit         mdr;

  always #5 clock = ~clock;

  universal_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q), .sout(sout),
    .shift_cnt(shift_cnt), .drained(drained)
  );

  universal_shift_reg #(.WIDTH(8), .NEG_EDGE(1'b0)) dut_pos (
    .clock(clock), .reset(reset), .clear(clear), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q_p), .sout(sout_p),
    .shift_cnt(cnt_p), .drained(drained_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sout();
    int v = int'(mq);
    if (mode == 2'b01) return logic'(v % 2);
    if (mode == 2'b10) return logic'(v / 128);
    return 1'b0;
  endfunction

  // One active edge of the reference model, from the textual rules.
  task automatic model_edge();
    int v = int'(mq);
    int inb;
    if (clear) begin
      mq = 8'h00; mcnt = 0; mdr = 1'b0;
    end else if (en) begin
      if (mode == 2'b11) begin
        mq = d; mcnt = 0; mdr = 1'b0;
      end else if (mode != 2'b00) begin
        if (mode == 2'b01) begin
          inb = rot ? v % 2 : int'(sin_r);
          v = v / 2 + inb * 128;
        end else begin
          inb = rot ? v / 128 : int'(sin_l);
          v = (v * 2) % 256 + inb;
        end
        mq = 8'(v);
        mcnt = (mcnt + 1 > 8) ? 8 : mcnt + 1;
        if (!rot && mcnt == 8) mdr = 1'b1;
      end
    end
  endtask

  // Called at falling edge + 1; returns sout seen before the edge.
  task automatic step(input logic c, input logic e, input logic [1:0] m, input logic r,
                      input logic sr, input logic sl, input logic [7:0] dv,
                      input string tag, output logic so);
    clear = c; en = e; mode = m; rot = r; sin_r = sr; sin_l = sl; d = dv;
    #1;
    so = sout;
    chk({tag, "_sout"}, 32'(sout), 32'(exp_sout()));
    @(negedge clock); #1;
    model_edge();
    chk({tag, "_q"}, 32'(q), 32'(mq));
    chk({tag, "_cnt"}, 32'(shift_cnt), 32'(mcnt));
    chk({tag, "_drained"}, 32'(drained), 32'(mdr));
  endtask

  initial begin
    logic       so;
    logic [7:0] seq;
    reset = 1'b1; clear = 1'b0; en = 1'b1; mode = 2'b11; rot = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; d = 8'hFF;
    mq = 8'h00; mcnt = 0; mdr = 1'b0;

    // Reset held across both edges with a pending load: nothing gets in
    #11;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_cnt", 32'(shift_cnt), 32'h0);
    chk("rst_drained", 32'(drained), 32'h0);
    chk("rst_q_pos", 32'(q_p), 32'h00);
    mode = 2'b00; en = 1'b0;
    #1 reset = 1'b0;
    @(negedge clock); #1;

    // Load timing on both edge selections
    en = 1'b1; mode = 2'b11; d = 8'h5A;
    #5;
    chk("pos_load_rise", 32'(q_p), 32'h5A);
    chk("neg_nochg_rise", 32'(q), 32'h00);
    d = 8'hA5;
    @(negedge clock); #1;
    chk("neg_load_q", 32'(q), 32'hA5);
    chk("neg_load_cnt", 32'(shift_cnt), 32'h0);
    chk("pos_nochg_fall", 32'(q_p), 32'h5A);
    mq = 8'hA5; mcnt = 0; mdr = 1'b0;

    // Drain A5 out to the right with zeros
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'h00, "drain", so);
      chk("drain_sout_seq", 32'(so), 32'(seq[7 - i]));
      chk("drain_flag", 32'(drained), (i == 7) ? 32'h1 : 32'h0);
    end
    chk("drain_end_q", 32'(q), 32'h00);
    chk("drain_end_cnt", 32'(shift_cnt), 32'h8);

    // Rotate left from 81
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h81, "ld81", so);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'h00, "rotl", so);
    chk("rotl_q", 32'(q), 32'h0C);
    chk("rotl_cnt", 32'(shift_cnt), 32'h3);
    chk("rotl_drained", 32'(drained), 32'h0);
    // Saturate via rotation: no drain until a serial shift
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'h00, "rotl_sat", so);
    chk("rot_sat_cnt", 32'(shift_cnt), 32'h8);
    chk("rot_sat_drained", 32'(drained), 32'h0);
    step(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, "serial_sat", so);
    chk("serial_sat_drained", 32'(drained), 32'h1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, "rot_after_drain", so);
    chk("rot_keeps_drained", 32'(drained), 32'h1);
    chk("rot_keeps_cnt", 32'(shift_cnt), 32'h8);

    // Clear beats load; disabled shift holds
    step(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hFF, "clr_vs_load", so);
    chk("clr_wins_q", 32'(q), 32'h00);
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h5A, "ld5a", so);
    step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, "en_off", so);
    chk("en_off_q", 32'(q), 32'h5A);

    // Asynchronous reset mid-sequence
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'hF0, "ldf0", so);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, "pre_rst", so);
    reset = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'h00);
    chk("async_rst_cnt", 32'(shift_cnt), 32'h0);
    chk("async_rst_drained", 32'(drained), 32'h0);
    mq = 8'h00; mcnt = 0; mdr = 1'b0;
    clear = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF;
    @(negedge clock); #1;
    chk("rst_blocks_load", 32'(q), 32'h00);
    reset = 1'b0;
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, "ld3c", so);
    chk("post_rst_load", 32'(q), 32'h3C);

    // Random operations against the model
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           8'($urandom), "rand", so);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter NEG_EDGE, default 1, active clock edge: 1 = falling edge of clock, 0 = rising edge.
REQ-003 Parameter CW, default $clog2(WIDTH)+1, shift-count width.
REQ-004 clock  input  1  single clock; all state updates occur only on the active edge selected by NEG_EDGE.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 clear  input  1  synchronous active-high clear, sampled on the active edge.
REQ-007 en  input  1  update enable; when 0, all state holds.
REQ-008 mode  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-009 rot  input  1  1 = rotate (wrap shifted-out bit back in), 0 = shift with serial input.
REQ-010 sin_r  input  1  serial input entering q[WIDTH-1] on shift right.
REQ-011 sin_l  input  1  serial input entering q[0] on shift left.
REQ-012 d  input  WIDTH  parallel load data.
REQ-013 q  output  WIDTH  registered register contents.
REQ-014 sout  output  1  combinational: q[0] when mode=01, q[WIDTH-1] when mode=10, 0 otherwise.
REQ-015 shift_cnt  output  CW  registered count of shifts since the last load/clear/reset.
REQ-016 drained  output  1  registered flag: 1 when shift_cnt = WIDTH and the last shift was non-rotating.

Function
REQ-017 Priority on each active edge SHALL be: clear, then en=0 (hold), then mode.
REQ-018 clear=1 SHALL set q=0, shift_cnt=0, drained=0 regardless of en, mode, rot.
REQ-019 mode=00 with en=1 SHALL hold q, shift_cnt, drained.
REQ-020 mode=01, rot=0: q <= {sin_r, q[WIDTH-1:1]}; shifted-out bit is q[0].
REQ-021 mode=10, rot=0: q <= {q[WIDTH-2:0], sin_l}; shifted-out bit is q[WIDTH-1].
REQ-022 mode=01, rot=1: q <= {q[0], q[WIDTH-1:1]}; sin_r ignored.
REQ-023 mode=10, rot=1: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin_l ignored.
REQ-024 mode=11: q <= d, shift_cnt <= 0, drained <= 0; update latency one active edge.
REQ-025 Each shift (mode 01/10, en=1) SHALL increment shift_cnt by 1, saturating at WIDTH (no wrap-around).
REQ-026 drained SHALL go 1 on the edge where shift_cnt reaches WIDTH via a rot=0 shift; a rot=1 shift at saturation SHALL leave drained unchanged.
REQ-027 drained SHALL stay 1 while further rot=0 shifts occur at saturation; cleared only by load, clear or reset.
REQ-028 Direction change mid-sequence (01 <-> 10) SHALL not reset shift_cnt; it keeps counting.
REQ-029 No state change SHALL occur on the inactive clock edge.
REQ-030 sout SHALL reflect current q combinationally, valid before the next active edge.

Reset
REQ-031 reset=1 SHALL immediately (no clock) force q=0, shift_cnt=0, drained=0.
REQ-032 reset asserted mid-shift-sequence SHALL abort it; after deassertion the first active edge behaves as from the reset state.
REQ-033 While reset=1, clear, en, mode and data inputs SHALL have no effect.
REQ-034 Before the first reset or clear, q is unspecified; the bench SHALL apply reset at time 0.

Verification (WIDTH=8, NEG_EDGE=1, clock period 10 units)
REQ-035 Load d=8'hA5, mode=11 at a falling edge -> q=8'hA5, shift_cnt=0 after that edge; no change on the rising edge.
REQ-036 From q=8'hA5, mode=01, rot=0, sin_r=0, 8 falling edges -> sout sequence 1,0,1,0,0,1,0,1; q=8'h00; shift_cnt=8; drained=1 on 8th edge.
REQ-037 From q=8'h81, mode=10, rot=1, 3 edges -> q=8'h0C; shift_cnt=3; drained=0.
REQ-038 clear=1 and mode=11 with d=8'hFF on same edge -> q=8'h00 (clear wins); en=0 with mode=01 -> q unchanged.
REQ-039 reset pulse between clock edges after 4 shifts -> q=0, shift_cnt=0 immediately; next load d=8'h3C -> q=8'h3C.
REQ-040 Rerun REQ-035 with NEG_EDGE=0 -> updates occur on rising edges only.
